// File: rtl/sreg_wr_arbiter_if.sv
// Write-port bus for the special register file arbiter: requester handshake,
// clear control, and the registered write port that feeds sreg_file.
interface sreg_wr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 128,
    parameter int ID_W    = 3
);
    logic                       clr_start;
    logic                       clr_busy;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic                       sreg_we;
    logic [ADDR_W-1:0]          sreg_waddr;
    logic [DATA_W-1:0]          sreg_wdata;
    logic [ID_W-1:0]            grant_id;

    modport master (
        output clr_start, req_valid, req_addr, req_data,
        input  clr_busy, req_ready, sreg_we, sreg_waddr, sreg_wdata, grant_id
    );

    modport slave (
        input  clr_start, req_valid, req_addr, req_data,
        output clr_busy, req_ready, sreg_we, sreg_waddr, sreg_wdata, grant_id
    );
endinterface

// File: rtl/sreg_wr_arbiter.sv
// Round-robin owner of the sreg_file write port, with a built-in sequence
// that zeroes every register one address per cycle.
module sreg_wr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 128,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    sreg_wr_arbiter_if.slave   bus
);
    localparam int SLOTS = 2**ID_W;

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
    logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   waddr_reg, waddr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [ID_W-1:0]     gid_reg, gid_next;
    logic                busy_reg, busy_next;

    logic [ADDR_W-1:0]   addr_arr [SLOTS];
    logic [DATA_W-1:0]   data_arr [SLOTS];
    logic [ID_W-1:0]     winner, hi_idx, lo_idx;
    logic                hi_found, lo_found, any_valid, ready_en;

    // Unpack per-requester fields into arrays sized to the full grant_id range
    // so the winner index selects without width adaptation.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_unpack
            if (gi < NUM_REQ) begin : g_used
                assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
                assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign addr_arr[gi] = '0;
                assign data_arr[gi] = '0;
            end
        end
    endgenerate

    // Lowest valid index above rr_ptr wins; otherwise wrap to lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (i > int'(rr_ptr_reg)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(i);
                end
            end
        end
        winner    = hi_found ? hi_idx : lo_idx;
        any_valid = hi_found | lo_found;
    end

    assign ready_en = !rst && (state_reg == IDLE) && !bus.clr_start && any_valid;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = ready_en && (winner == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        rr_ptr_next  = rr_ptr_reg;
        we_next      = 1'b0;
        waddr_next   = waddr_reg;
        wdata_next   = wdata_reg;
        gid_next     = gid_reg;
        busy_next    = busy_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clr_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                    busy_next    = 1'b1;
                end else if (any_valid) begin
                    we_next     = 1'b1;
                    waddr_next  = addr_arr[winner];
                    wdata_next  = data_arr[winner];
                    gid_next    = winner;
                    rr_ptr_next = winner;
                end
            end
            CLEAR: begin
                we_next      = 1'b1;
                waddr_next   = clr_cnt_reg;
                wdata_next   = '0;
                clr_cnt_next = clr_cnt_reg + 1'b1;
                // Busy drops on the same edge that presents the final zero write.
                if (clr_cnt_reg == '1) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            clr_cnt_reg <= '0;
            rr_ptr_reg  <= ID_W'(NUM_REQ - 1);
            we_reg      <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            gid_reg     <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            rr_ptr_reg  <= rr_ptr_next;
            we_reg      <= we_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
            gid_reg     <= gid_next;
            busy_reg    <= busy_next;
        end
    end

    assign bus.sreg_we    = we_reg;
    assign bus.sreg_waddr = waddr_reg;
    assign bus.sreg_wdata = wdata_reg;
    assign bus.grant_id   = gid_reg;
    assign bus.clr_busy   = busy_reg;
endmodule
